// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexing controller for a four-digit seven-segment display.
//
// Steps a digit pointer through digits 0..3, one slot of TICK_DIV cycles each. Every slot starts
// with BLANK_CYC cycles of all anodes off, which hides ghosting while the shared hex7seg decoder
// settles on the next nibble. Display values are double-buffered: `load` writes a pending buffer,
// and the active buffer only takes it at a frame boundary (the last on-cycle of digit 3).
//
// Optional build macro:
//   SEG_SCAN_LZ_BLANK_EN  leading-zero suppression on digits 3..1 (digit 0 is never suppressed).
//
// Parameters:
//   TICK_DIV   cycles per digit slot, 4..2^20
//   BLANK_CYC  blank cycles at the start of each slot, 1..TICK_DIV-1
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   load        one-cycle strobe, captures data_in/dp_in/en_in into the pending buffer
//   data_in     four hex digits, digit i = data_in[4i+3:4i]
//   dp_in       decimal-point request per digit, active high
//   en_in       per-digit enable
//   nibble      selected digit value for the hex7seg decoder (combinational)
//   an          anodes, active low, registered
//   dp_n        decimal point, active low, registered
//   dig         current digit pointer
//   frame_done  one-cycle pulse aligned with the first blank cycle of digit 0
//   upd_pend    pending buffer holds data not yet shown
module seg_scan_ctrl #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic [1:0]  dig,
  output logic        frame_done,
  output logic        upd_pend
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] CntSlotLast  = CntW'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    StBlank,
    StOn
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;

  logic [15:0] act_data_q, act_data_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic [3:0]  act_en_q, act_en_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [3:0]  pend_en_q, pend_en_d;
  logic        upd_pend_q, upd_pend_d;

  logic [3:0]  an_q, an_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_done_q, frame_done_d;

  logic        slot_end;
  logic        frame_end;
  logic [3:0]  sup_d;

  assign slot_end  = (state_q == StOn) && (cnt_q == CntSlotLast);
  assign frame_end = slot_end && (dig_q == 2'd3);

  // Slot sequencing and double buffering.
  always_comb begin
    state_d      = state_q;
    dig_d        = dig_q;
    cnt_d        = slot_end ? '0 : cnt_q + CntW'(1);
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    upd_pend_d   = upd_pend_q;
    frame_done_d = frame_end;

    unique case (state_q)
      StBlank: begin
        // cnt keeps running into the on-phase; only the slot end clears it.
        if (cnt_q == CntBlankLast) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (slot_end) begin
          state_d = StBlank;
          dig_d   = dig_q + 2'd1;
        end
      end
      default: state_d = StBlank;
    endcase

    // Transfer uses the pending contents held before this edge, so a load on the boundary edge
    // is not shown until the following frame.
    if (frame_end && upd_pend_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      act_en_d   = pend_en_q;
    end

    if (load) begin
      pend_data_d = data_in;
      pend_dp_d   = dp_in;
      pend_en_d   = en_in;
      upd_pend_d  = 1'b1;
    end else if (frame_end) begin
      upd_pend_d = 1'b0;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // A digit is a leading zero when it is 0 and every enabled digit above it is 0 as well.
  always_comb begin : lz_blank
    logic higher_zero;
    sup_d       = '0;
    higher_zero = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if ((act_data_d[4*i +: 4] == 4'h0) && higher_zero) begin
        sup_d[i] = 1'b1;
      end
      if (act_en_d[i] && (act_data_d[4*i +: 4] != 4'h0)) begin
        higher_zero = 1'b0;
      end
    end
  end
`else
  assign sup_d = 4'b0000;
`endif

  // Registered outputs follow the next state so they line up with state_q.
  always_comb begin
    an_d   = 4'b1111;
    dp_n_d = 1'b1;
    if (state_d == StOn) begin
      if (act_en_d[dig_d] && !sup_d[dig_d]) begin
        an_d[dig_d] = 1'b0;
      end
      dp_n_d = ~(act_dp_d[dig_d] & act_en_d[dig_d] & ~sup_d[dig_d]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      upd_pend_q   <= 1'b0;
      an_q         <= 4'b1111;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      upd_pend_q   <= upd_pend_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Driven from the registered pointer, so the decoder input is stable for the whole slot.
  assign nibble     = act_data_q[{dig_q, 2'b00} +: 4];
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign dig        = dig_q;
  assign frame_done = frame_done_q;
  assign upd_pend   = upd_pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with TICK_DIV = 8, BLANK_CYC = 2 (32-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp_n;
  logic [1:0]  dig;
  logic        frame_done;
  logic        upd_pend;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_ctrl #(
    .TICK_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .nibble     (nibble),
    .an         (an),
    .dp_n       (dp_n),
    .dig        (dig),
    .frame_done (frame_done),
    .upd_pend   (upd_pend)
  );

  always #5 clk = ~clk;

  // Expected on-phase anode pattern per slot in an_on[4s+:4], on-phase dp_n per slot in dpn_on[s].
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [15:0] an_on;
    logic [3:0]  dpn_on;
  } vec_t;

  vec_t tbl[5];
  vec_t v_abcd, v_1111, v_2222;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    load    = 1'b1;
    data_in = d;
    dp_in   = p;
    en_in   = e;
  endtask

  // Returns at the first sampled cycle with frame_done high (first blank cycle of digit 0).
  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_frame_done", 16'(found), 16'd1);
  endtask

  // Checks one whole frame starting at its first cycle; ends on the first cycle of the next frame.
  task automatic check_frame(input vec_t v, input logic pend);
    for (int c = 0; c < 32; c++) begin
      int s;
      int k;
      s = c / 8;
      k = c % 8;
      chk("nibble", 16'(nibble), 16'(v.data[4*s +: 4]));
      chk("an", 16'(an), (k < 2) ? 16'hF : 16'(v.an_on[4*s +: 4]));
      chk("dp_n", 16'(dp_n), (k < 2) ? 16'd1 : 16'(v.dpn_on[s]));
      chk("dig", 16'(dig), 16'(s));
      chk("frame_done", 16'(frame_done), 16'(c == 0));
      chk("upd_pend_frame", 16'(upd_pend), 16'(pend));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{data: 16'h0040, dp: 4'hF, en: 4'hF,
`ifdef SEG_SCAN_LZ_BLANK_EN
               an_on: 16'hFFDE, dpn_on: 4'b1100};
`else
               an_on: 16'h7BDE, dpn_on: 4'b0000};
`endif
    tbl[1] = '{data: 16'h9876, dp: 4'hF, en: 4'b0101, an_on: 16'hFBFE, dpn_on: 4'b1010};
    tbl[2] = '{data: 16'h0000, dp: 4'h0, en: 4'h0,    an_on: 16'hFFFF, dpn_on: 4'b1111};
    tbl[3] = '{data: 16'hABCD, dp: 4'h0, en: 4'hF,    an_on: 16'h7BDE, dpn_on: 4'b1111};
    tbl[4] = '{data: 16'h4321, dp: 4'b0100, en: 4'hF, an_on: 16'h7BDE, dpn_on: 4'b1011};
    v_abcd = '{data: 16'hABCD, dp: 4'h0, en: 4'hF, an_on: 16'h7BDE, dpn_on: 4'b1111};
    v_1111 = '{data: 16'h1111, dp: 4'h0, en: 4'hF, an_on: 16'h7BDE, dpn_on: 4'b1111};
    v_2222 = '{data: 16'h2222, dp: 4'h0, en: 4'hF, an_on: 16'h7BDE, dpn_on: 4'b1111};

    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    dp_in   = '0;
    en_in   = '0;
    repeat (2) step();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_dp_n", 16'(dp_n), 16'd1);
    chk("rst_dig", 16'(dig), 16'd0);
    chk("rst_nibble", 16'(nibble), 16'd0);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    chk("rst_upd_pend", 16'(upd_pend), 16'd0);

    // Slot 0 lasts exactly 8 edges after release; the display stays dark with empty buffers.
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("post_rst_dig", 16'(dig), (i == 8) ? 16'd1 : 16'd0);
      chk("post_rst_an", 16'(an), 16'hF);
    end

    // Table: load, expect upd_pend, wait for the boundary, then check every cycle of the frame.
    for (int t = 0; t < 5; t++) begin
      do_load(tbl[t].data, tbl[t].dp, tbl[t].en);
      step();
      load = 1'b0;
      chk("upd_pend_after_load", 16'(upd_pend), 16'd1);
      wait_frame();
      check_frame(tbl[t], 1'b0);
    end

    // Deferred update: load mid-frame, old digits stay until the boundary.
    repeat (12) step();
    do_load(16'hABCD, 4'h0, 4'hF);
    step();
    load = 1'b0;
    chk("defer_an", 16'(an), 16'hD);
    for (int c = 13; c < 32; c++) begin
      chk("defer_upd_pend", 16'(upd_pend), 16'd1);
      chk("defer_nibble", 16'(nibble), 16'((c / 8) + 1));
      step();
    end
    check_frame(v_abcd, 1'b0);

    // Collision: second load lands exactly on the boundary edge.
    do_load(16'h1111, 4'h0, 4'hF);
    step();
    load = 1'b0;
    repeat (30) step();
    do_load(16'h2222, 4'h0, 4'hF);
    step();
    load = 1'b0;
    check_frame(v_1111, 1'b1);
    check_frame(v_2222, 1'b0);

    // Asynchronous reset mid-slot with a pending update outstanding.
    do_load(16'h5555, 4'hF, 4'hF);
    step();
    load = 1'b0;
    repeat (10) step();
    chk("pre_rst_an", 16'(an), 16'hD);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_an", 16'(an), 16'hF);
    chk("async_rst_dp_n", 16'(dp_n), 16'd1);
    chk("async_rst_dig", 16'(dig), 16'd0);
    chk("async_rst_upd_pend", 16'(upd_pend), 16'd0);
    chk("async_rst_nibble", 16'(nibble), 16'd0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("rst2_dig", 16'(dig), (i == 8) ? 16'd1 : 16'd0);
      chk("rst2_an", 16'(an), 16'hF);
    end
    wait_frame();
    chk("lost_pend_upd", 16'(upd_pend), 16'd0);
    chk("lost_pend_nibble", 16'(nibble), 16'd0);
    chk("lost_pend_an", 16'(an), 16'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the four-digit seven-segment display. It owns the single shared `hex7seg` decoder: it steps a digit pointer through digits 0..3, presents the selected nibble to the decoder, and drives the active-low anodes and decimal point. Each digit slot starts with an anti-ghosting blank interval. New display values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `TICK_DIV`, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 4..2^20.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off; must be ≥1 and < `TICK_DIV`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `data_in`, `dp_in`, `en_in` into the pending buffer.
- `data_in`  in  16  four hex digits; digit i = `data_in[4i+3:4i]`.
- `dp_in`  in  4  decimal-point request per digit, active high.
- `en_in`  in  4  per-digit enable; a disabled digit stays dark in its slot.
- `nibble`  out  4  digit value, wired to `hex7seg.n`.
- `an`  out  4  anodes, active low, registered.
- `dp_n`  out  1  decimal point, active low, registered.
- `dig`  out  2  current digit pointer.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.
- `upd_pend`  out  1  high while the pending buffer holds data not yet shown.

## Operation
- Registers: active {data, dp, en}; pending {data, dp, en}; `upd_pend`; `dig`; slot counter `cnt`, `$clog2(TICK_DIV)` bits; FSM state.
- FSM states:
  - `S_BLANK`: `an` = 4'b1111, `dp_n` = 1. When `cnt` = `BLANK_CYC`−1, go to `S_ON`.
  - `S_ON`: `an[dig]` = 0 if active `en[dig]`, all other anode bits 1; `dp_n` = ~(active `dp[dig]` & active `en[dig]`). When `cnt` = `TICK_DIV`−1, clear `cnt`, set `dig` ← `dig`+1 (wraps 3→0), and go to `S_BLANK`.
- `cnt` increments every cycle, clears at the end of each slot, and is never reset at the BLANK→ON change.
- `nibble` = active `data[4*dig+3 : 4*dig]` in both states, so the decoder settles during the blank interval.
- Frame boundary is the final `S_ON` cycle of digit 3. On that edge:
  - `frame_done` pulses high for one cycle, aligned with the first `S_BLANK` cycle of digit 0.
  - If `upd_pend` = 1, the active buffer takes the pending buffer and `upd_pend` clears.
- `load` writes the pending buffer and sets `upd_pend`. A second `load` before the boundary overwrites pending; the last write wins.
- `load` on the boundary edge:
  - The transfer uses the pending contents held before that edge.
  - The new load lands in pending, and `upd_pend` is 1 afterwards.
- Reset values: `dig` = 0, state `S_BLANK`, `cnt` = 0, `an` = 4'b1111, `dp_n` = 1, `nibble` = 0, `frame_done` = 0, `upd_pend` = 0, both buffers cleared (en = 0, so the display is dark).
- Reset mid-slot: outputs go to reset values immediately (asynchronously). Scanning restarts from digit 0 `S_BLANK` on the first edge after release. Pending data is lost.

## Timing
- Slot length = `TICK_DIV` cycles: `BLANK_CYC` blank, then `TICK_DIV`−`BLANK_CYC` on. Frame length = 4·`TICK_DIV` cycles.
- `an`, `dp_n`, `frame_done` are registered and change only on `clk` edges (except during asynchronous reset).
- `nibble` is combinational from registered `dig` and the active buffer, so it is stable for the whole slot.
- Load-to-display latency: from 1 cycle (load on the cycle before a boundary) up to one full frame plus 1 cycle.
- `upd_pend` is high from the edge after `load` until the boundary edge.

## Configuration
- `SEG_SCAN_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digit i (i = 1..3) is forced dark, with `dp_n` = 1, when its nibble and all higher enabled nibbles are 0.
  - Digit 0 is never suppressed.
  - Example: active data 16'h0040 lights only digits 1 and 0.
- Macro undefined: every enabled digit is shown, zeros included.

## Test plan
- Reset check: assert `reset` mid-run → `an` = 4'hF, `dp_n` = 1, `dig` = 0, `upd_pend` = 0 at once; after release, the first `S_ON` for digit 0 starts `BLANK_CYC` cycles later.
- Scan order (`TICK_DIV` = 8, `BLANK_CYC` = 2), load 16'h4321, en = 4'hF, dp = 4'b0100:
  - `an` goes 1111,1111, then 1110 ×6; next slot 1111 ×2, then 1101 ×6; and so on through digit 3.
  - `nibble` reads 1, 2, 3, 4 in successive slots.
  - `dp_n` is 0 only in digit 2's on-phase.
  - `frame_done` pulses every 32 cycles.
- Deferred update: load 16'hABCD mid-frame → the active display is unchanged until `frame_done`; `upd_pend` stays high until then; the next frame shows D, C, B, A.
- Collision: load 16'h1111, then load 16'h2222 on the boundary cycle → the next frame shows 1111; `upd_pend` = 1; the following frame shows 2222.
- Enable mask: en = 4'b0101 → `an` never drives bits 1 or 3 low; slot timing is unchanged.
- Macro on, data 16'h0040 → digits 3 and 2 stay dark. Macro off → all four digits light.
